// File: rtl/nn_param_pkg.sv
// rtl/nn_param_pkg.sv - shared constants, selector encodings and loader states for the parameter chain
package nn_param_pkg;

    localparam int DATA_W            = 8;
    localparam int NUM_NEURONS       = 4;
    localparam int PARAMS_PER_NEURON = 6;
    localparam int FRAME_LEN         = NUM_NEURONS * PARAMS_PER_NEURON;

    localparam logic [1:0] SEL_HOLD  = 2'b00;
    localparam logic [1:0] SEL_SHIFT = 2'b01;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_FLUSH,
        ST_CHECK,
        ST_DONE
    } loader_state_t;

endpackage

// File: rtl/param_chain_loader.sv
// rtl/param_chain_loader.sv - byte stream to neuron parameter shift chain loader
// Optional trailing checksum byte enabled by PARAM_LOADER_CHECKSUM_EN.
module param_chain_loader #(
    parameter int  DATA_W            = nn_param_pkg::DATA_W,
    parameter int  NUM_NEURONS       = nn_param_pkg::NUM_NEURONS,
    parameter int  PARAMS_PER_NEURON = nn_param_pkg::PARAMS_PER_NEURON,
    localparam int FRAME_LEN         = NUM_NEURONS * PARAMS_PER_NEURON,
    localparam int CNT_W             = $clog2(FRAME_LEN + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    output logic [DATA_W-1:0] chain_data,
    output logic [1:0]        chain_sel,
    output logic [CNT_W-1:0]  byte_cnt,
    output logic              busy,
    output logic              done,
    output logic              err
);

    import nn_param_pkg::loader_state_t;
    import nn_param_pkg::ST_IDLE;
    import nn_param_pkg::ST_LOAD;
    import nn_param_pkg::ST_FLUSH;
    import nn_param_pkg::ST_CHECK;
    import nn_param_pkg::ST_DONE;
    import nn_param_pkg::SEL_HOLD;
    import nn_param_pkg::SEL_SHIFT;

    loader_state_t state, state_nxt;
    logic          load_accept;
    logic          start_frame;
    logic          last_byte;

    assign load_accept = (state == ST_LOAD) && s_valid;
    assign start_frame = (state == ST_IDLE) && start;
    assign last_byte   = (byte_cnt == CNT_W'(FRAME_LEN - 1));

    always_comb begin
        state_nxt = state;
        s_ready   = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                s_ready = 1'b1;
                busy    = 1'b1;
                if (s_valid && last_byte) state_nxt = ST_FLUSH;
            end
            ST_FLUSH: begin
                busy = 1'b1;
`ifdef PARAM_LOADER_CHECKSUM_EN
                state_nxt = ST_CHECK;
`else
                state_nxt = ST_DONE;
`endif
            end
            ST_CHECK: begin
`ifdef PARAM_LOADER_CHECKSUM_EN
                s_ready = 1'b1;
                busy    = 1'b1;
                if (s_valid) state_nxt = ST_DONE;
`else
                state_nxt = ST_IDLE;
`endif
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Chain outputs are registered: a byte accepted at edge N is shifted into the chain at edge N+1.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            chain_data <= '0;
            chain_sel  <= SEL_HOLD;
            byte_cnt   <= '0;
        end else begin
            state     <= state_nxt;
            chain_sel <= load_accept ? SEL_SHIFT : SEL_HOLD;
            if (load_accept) begin
                chain_data <= s_data;
                byte_cnt   <= byte_cnt + 1'b1;
            end else if (start_frame) begin
                byte_cnt <= '0;
            end
        end
    end

`ifdef PARAM_LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] sum;
    logic              err_q;

    // The checksum byte is compared against the wrapped sum of the frame bytes, never forwarded.
    always_ff @(posedge clk) begin
        if (reset) begin
            sum   <= '0;
            err_q <= 1'b0;
        end else if (start_frame) begin
            sum   <= '0;
            err_q <= 1'b0;
        end else if (load_accept) begin
            sum <= sum + s_data;
        end else if ((state == ST_CHECK) && s_valid) begin
            err_q <= (s_data != sum);
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_param_chain_loader.sv
// tb/tb_param_chain_loader.sv - self-checking bench for param_chain_loader with a chain and protocol model
module tb_param_chain_loader;

    localparam int FL = 24;
`ifdef PARAM_LOADER_CHECKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       s_valid = 1'b0;
    logic [7:0] s_data = 8'h00;
    logic       s_ready;
    logic [7:0] chain_data;
    logic [1:0] chain_sel;
    logic [4:0] byte_cnt;
    logic       busy;
    logic       done;
    logic       err;

    always #5 clk = ~clk;

    param_chain_loader dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_ready    (s_ready),
        .chain_data (chain_data),
        .chain_sel  (chain_sel),
        .byte_cnt   (byte_cnt),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Downstream shift chain: entry 0 is neuron0 w0, entry 23 is neuron3 th.
    logic [7:0] chain [FL];
    int shifts = 0;
    int dones  = 0;
    always @(posedge clk) begin
        if (chain_sel === 2'b01) begin
            for (int i = 0; i < FL - 1; i++) chain[i] <= chain[i + 1];
            chain[FL - 1] <= chain_data;
            shifts++;
        end
        if (done === 1'b1) dones++;
    end

    // Protocol model: phase 0 idle, 1 load, 2 flush, 3 check, 4 done.
    int         m_ph  = 0;
    int         m_cnt = 0;
    logic [7:0] m_data = 8'h00;
    logic [7:0] m_sum  = 8'h00;
    logic       m_sel  = 1'b0;
    logic       m_err  = 1'b0;
    always @(posedge clk) begin
        if (reset) begin
            m_ph = 0; m_cnt = 0; m_data = 8'h00; m_sum = 8'h00; m_sel = 1'b0; m_err = 1'b0;
        end else begin
            m_sel = 1'b0;
            case (m_ph)
                0: if (start) begin m_ph = 1; m_cnt = 0; m_err = 1'b0; m_sum = 8'h00; end
                1: if (s_valid) begin
                    m_sel = 1'b1; m_data = s_data; m_cnt++; m_sum = m_sum + s_data;
                    if (m_cnt == FL) m_ph = 2;
                end
                2: m_ph = CK ? 3 : 4;
                3: if (s_valid) begin m_err = (s_data != m_sum); m_ph = 4; end
                default: m_ph = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("s_ready", s_ready, (m_ph == 1) || (m_ph == 3));
            chk("chain_sel", chain_sel, m_sel ? 2'b01 : 2'b00);
            chk("chain_data", chain_data, m_data);
            chk("byte_cnt", byte_cnt, m_cnt);
            chk("busy", busy, (m_ph >= 1) && (m_ph <= 3));
            chk("done", done, m_ph == 4);
            chk("err", err, m_err);
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit rnd);
        int budget;
        bit sent;
        bit rdy;
        budget = 200;
        sent = 1'b0;
        s_data = b;
        while (!sent && budget > 0) begin
            rdy = (m_ph == 1) || (m_ph == 3);
            s_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            tick();
            if (s_valid && rdy) sent = 1'b1;
            budget--;
        end
        s_valid = 1'b0;
        chk("send_budget", sent, 1'b1);
    endtask

    task automatic wait_idle;
        int budget;
        budget = 20;
        while (m_ph != 0 && budget > 0) begin
            tick();
            budget--;
        end
        tick();
        chk("idle_budget", m_ph, 0);
    endtask

    task automatic send_frame(input bit rnd, input int start_at, input logic [7:0] csum);
        shifts = 0;
        dones = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < FL; k++) begin
            if (k == start_at) start = 1'b1;
            send_byte(8'(k + 1), rnd);
            start = 1'b0;
        end
        if (CK) send_byte(csum, 1'b0);
        wait_idle();
    endtask

    task automatic check_frame(input string tag, input logic exp_err);
        for (int i = 0; i < FL; i++) chk({tag, "_chain"}, chain[i], i + 1);
        chk({tag, "_shifts"}, shifts, FL);
        chk({tag, "_dones"}, dones, 1);
        chk({tag, "_byte_cnt"}, byte_cnt, FL);
        chk({tag, "_err"}, err, exp_err);
    endtask

    initial begin
        reset = 1'b1;
        tick();
        chk_en = 1'b1;
        tick();
        chk("rst_s_ready", s_ready, 0);
        chk("rst_chain_sel", chain_sel, 0);
        chk("rst_chain_data", chain_data, 0);
        chk("rst_byte_cnt", byte_cnt, 0);
        chk("rst_busy_done", {busy, done, err}, 0);
        reset = 1'b0;
        tick();

        // Abort mid-frame after 10 bytes.
        dones = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 10; k++) send_byte(8'hA0 + 8'(k), 1'b0);
        chk("mid_byte_cnt", byte_cnt, 10);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_chain_sel", chain_sel, 0);
        chk("abort_s_ready", s_ready, 0);
        chk("abort_byte_cnt", byte_cnt, 0);
        tick();
        tick();
        chk("abort_dones", dones, 0);

        // Back-to-back full frame; checksum 0x2C is correct for 0x01..0x18.
        send_frame(1'b0, -1, 8'h2C);
        check_frame("b2b", 1'b0);

        // Bytes offered in IDLE after a frame must stay upstream.
        shifts = 0;
        s_data = 8'h99;
        s_valid = 1'b1;
        repeat (6) tick();
        s_valid = 1'b0;
        chk("idle_shifts", shifts, 0);
        chk("idle_byte_cnt", byte_cnt, FL);

        send_frame(1'b1, -1, 8'h2C);
        check_frame("rnd", 1'b0);

        send_frame(1'b0, 5, 8'h2C);
        check_frame("start_in_load", 1'b0);

`ifdef PARAM_LOADER_CHECKSUM_EN
        send_frame(1'b0, -1, 8'h2D);
        check_frame("bad_csum", 1'b1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
